// File: rtl/winner_policy_seq_pkg.sv
// Shared definitions for the winner-policy engine and its sequencer.
package winner_policy_seq_pkg;

    localparam int unsigned WORD_WIDTH          = 16;
    localparam int unsigned NO_HOP              = 100;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;
    localparam int unsigned STATE_W             = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECAY  = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

endpackage

// File: rtl/winner_policy_seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module winner_policy_seq_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/winner_policy_seq.sv
// Sequencer in front of the winner-policy engine: one request at a time,
// start pulse, bounded wait for done, epsilon decay, result handshake.
module winner_policy_seq
    import winner_policy_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  eps_load,
    input  logic [WORD_WIDTH-1:0] eps_init,
    input  logic [WORD_WIDTH-1:0] eps_step,
    output logic [WORD_WIDTH-1:0] epsilon,
    output logic                  pol_start,
    input  logic                  pol_done,
    input  logic [WORD_WIDTH-1:0] pol_nexthop,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WORD_WIDTH-1:0] res_nexthop,
    output logic                  res_timeout,
    output logic [WORD_WIDTH-1:0] dec_count,
    output logic [WORD_WIDTH-1:0] tmo_count,
    output logic [STATE_W-1:0]    cstate
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_e                state_q;
    logic                  req_ready_q;
    logic                  pol_start_q;
    logic                  res_valid_q;
    logic [WORD_WIDTH-1:0] res_nexthop_q;
    logic                  res_timeout_q;
    logic [WORD_WIDTH-1:0] eps_q;
    logic                  done_q;

    logic                  done_rise;
    logic                  wait_expired;
    logic [WORD_WIDTH-1:0] eps_decay_d;
    logic                  wait_clr;
    logic                  wait_inc;
    logic                  dec_inc;
    logic                  tmo_inc;
    logic [WAIT_W-1:0]     wait_cnt;

    // Edge detect on engine done, expiry test, floored decay and counter controls.
    always_comb begin
        done_rise    = pol_done & ~done_q;
        wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
        eps_decay_d  = (eps_q < eps_step) ? '0 : (eps_q - eps_step);
        wait_clr     = (state_q == ST_START);
        wait_inc     = (state_q == ST_WAIT);
        dec_inc      = (state_q == ST_DECAY);
        tmo_inc      = (state_q == ST_WAIT) && wait_expired && !done_rise;
    end

    winner_policy_seq_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (wait_clr),
        .inc_i   (wait_inc),
        .count_o (wait_cnt)
    );

    winner_policy_seq_sat_counter #(.W(WORD_WIDTH)) u_dec_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (1'b0),
        .inc_i   (dec_inc),
        .count_o (dec_count)
    );

    winner_policy_seq_sat_counter #(.W(WORD_WIDTH)) u_tmo_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (1'b0),
        .inc_i   (tmo_inc),
        .count_o (tmo_count)
    );

    // Sequencer FSM with registered outputs; eps_load overrides decay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            pol_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_nexthop_q <= WORD_WIDTH'(NO_HOP);
            res_timeout_q <= 1'b0;
            eps_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q      <= pol_done;
            pol_start_q <= 1'b0;

            if (eps_load) begin
                eps_q <= eps_init;
            end else if (state_q == ST_DECAY) begin
                eps_q <= eps_decay_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_START;
                        req_ready_q <= 1'b0;
                        pol_start_q <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        res_nexthop_q <= pol_nexthop;
                        res_timeout_q <= 1'b0;
                        state_q       <= ST_DECAY;
                    end else if (wait_expired) begin
                        res_nexthop_q <= WORD_WIDTH'(NO_HOP);
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESULT;
                    end
                end
                ST_DECAY: begin
                    res_valid_q <= 1'b1;
                    state_q     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign pol_start   = pol_start_q;
    assign res_valid   = res_valid_q;
    assign res_nexthop = res_nexthop_q;
    assign res_timeout = res_timeout_q;
    assign epsilon     = eps_q;
    assign cstate      = state_q;

endmodule

// File: tb/tb_winner_policy_seq.sv
// Scoreboard bench for winner_policy_seq with a cycle-level engine stand-in.
module tb_winner_policy_seq;
    import winner_policy_seq_pkg::*;

    localparam int unsigned T = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        eps_load;
    logic [15:0] eps_init;
    logic [15:0] eps_step;
    logic [15:0] epsilon;
    logic        pol_start;
    logic        pol_done;
    logic [15:0] pol_nexthop;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_nexthop;
    logic        res_timeout;
    logic [15:0] dec_count;
    logic [15:0] tmo_count;
    logic [2:0]  cstate;

    winner_policy_seq #(.TIMEOUT_CYC(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .eps_load    (eps_load),
        .eps_init    (eps_init),
        .eps_step    (eps_step),
        .epsilon     (epsilon),
        .pol_start   (pol_start),
        .pol_done    (pol_done),
        .pol_nexthop (pol_nexthop),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_nexthop (res_nexthop),
        .res_timeout (res_timeout),
        .dec_count   (dec_count),
        .tmo_count   (tmo_count),
        .cstate      (cstate)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] nh;
        logic        tmo;
        logic [15:0] eps;
        logic [15:0] dec;
        logic [15:0] tcnt;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int cyc    = 0;

    // reference model state
    logic [15:0] eps_m = 16'd0;
    int          dec_m = 0;
    int          tmo_m = 0;

    // engine stand-in controls
    int          eng_mode  = 0;   // 0 random delay, 1 fixed delay, 2 never done
    int          fix_d     = 1;
    bit          fix_nh_en = 1'b0;
    logic [15:0] fix_nh    = 16'd0;
    bit          dload_en  = 1'b0;
    logic [15:0] dload_val = 16'd0;
    logic        eng_done  = 1'b0;
    logic        stuck     = 1'b0;
    int          eng_cnt   = 0;
    bit          hold_ready = 1'b0;
    bit          rand_bp    = 1'b0;
    logic        pol_start_prev = 1'b0;

    assign pol_done = eng_done | stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Consumer ready, changed just after each rising edge.
    always @(posedge clock) begin
        #2;
        res_ready = hold_ready ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Engine stand-in: on start, pick delay/nexthop, push expectation, pulse done after the delay.
    always @(negedge clock) begin
        int          d;
        logic [15:0] nh;
        bit          to;
        exp_t        e;
        if (reset) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done = 1'b1;
            end
            if (pol_start) begin
                d  = (eng_mode == 1) ? fix_d : (eng_mode == 2) ? 0 : int'($urandom_range(1, T + 2));
                nh = fix_nh_en ? fix_nh : 16'($urandom_range(0, 255));
                pol_nexthop = nh;
                to = (d == 0) || (d > int'(T));
                if (to) begin
                    tmo_m++;
                    e.nh = 16'(NO_HOP);
                end else begin
                    dec_m++;
                    e.nh = nh;
                    if (dload_en) eps_m = dload_val;
                    else eps_m = (eps_m < eps_step) ? 16'd0 : eps_m - eps_step;
                end
                e.tmo  = to;
                e.eps  = eps_m;
                e.dec  = 16'(dec_m);
                e.tcnt = 16'(tmo_m);
                sb.push_back(e);
                eng_cnt = d;
            end
        end
    end

    // Monitor: compare each accepted result against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && pol_start) check("pol_start_width", 32'(pol_start_prev), 32'd0);
        pol_start_prev = pol_start;
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("res_nexthop", 32'(res_nexthop), 32'(e.nh));
                check("res_timeout", 32'(res_timeout), 32'(e.tmo));
                check("epsilon",     32'(epsilon),     32'(e.eps));
                check("dec_count",   32'(dec_count),   32'(e.dec));
                check("tmo_count",   32'(tmo_count),   32'(e.tcnt));
            end
            n_done++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'd1);
        check({tag, "_pol_start"},   32'(pol_start),   32'd0);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_res_nexthop"}, 32'(res_nexthop), 32'(NO_HOP));
        check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
        check({tag, "_epsilon"},     32'(epsilon),     32'd0);
        check({tag, "_dec_count"},   32'(dec_count),   32'd0);
        check({tag, "_tmo_count"},   32'(tmo_count),   32'd0);
        check({tag, "_cstate"},      32'(cstate),      32'd0);
    endtask

    task automatic flush_model();
        sb.delete();
        eps_m = 16'd0;
        dec_m = 0;
        tmo_m = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!req_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (n_done < target) check("wait_done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [15:0] s);
        wait_idle();
        eps_load = 1'b1;
        eps_init = v;
        eps_step = s;
        @(negedge clock);
        eps_load = 1'b0;
        eps_m    = v;
        check("eps_load_value", 32'(epsilon), 32'(v));
    endtask

    // Issue one request, check start timing and (lat >= 0) start-to-valid latency.
    task automatic run_one(input int lat);
        int snap;
        int t0;
        bit ok = 1'b0;
        wait_idle();
        snap = n_done;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        check("start_after_accept", 32'(pol_start), 32'd1);
        t0 = cyc;
        for (int k = 0; k < int'(T) + 20; k++) begin
            @(negedge clock);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("res_valid_timeout", 32'd0, 32'd1);
        else if (lat >= 0) check("start_to_valid", 32'(cyc - t0), 32'(lat));
        wait_done(snap + 1);
    endtask

    initial begin
        int snap;
        bit ok;
        reset     = 1'b1;
        req_valid = 1'b0;
        eps_load  = 1'b0;
        eps_init  = 16'd0;
        eps_step  = 16'd0;
        pol_nexthop = 16'd0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);

        // normal decision
        do_load(16'd10, 16'd3);
        eng_mode = 1; fix_d = 5; fix_nh_en = 1'b1; fix_nh = 16'd7;
        run_one(7);
        check("eps_after_decision", 32'(epsilon), 32'd7);

        // decay floor
        do_load(16'd2, 16'd3);
        fix_d = 2; fix_nh = 16'd11;
        run_one(4);
        check("eps_floor", 32'(epsilon), 32'd0);
        run_one(4);
        check("eps_floor_nowrap", 32'(epsilon), 32'd0);

        // timeout, epsilon untouched
        do_load(16'd9, 16'd2);
        eng_mode = 2;
        run_one(int'(T) + 1);
        check("eps_after_timeout", 32'(epsilon), 32'd9);

        // done on the last wait cycle still wins
        eng_mode = 1; fix_d = int'(T); fix_nh = 16'd33;
        run_one(int'(T) + 2);

        // backpressure
        fix_d = 3; fix_nh = 16'd42;
        wait_idle();
        snap = n_done;
        hold_ready = 1'b1;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bp_res_valid_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("bp_hold", {28'd0, res_valid, req_ready, (cstate == 3'd4), (res_nexthop == 16'd42)}, 32'b1011);
        end
        hold_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (pol_start) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        check("bp_second_req_started", 32'(ok), 32'd1);
        wait_done(snap + 2);

        // stuck-high done from reset
        reset = 1'b1;
        stuck = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        flush_model();
        eng_mode = 2;
        run_one(int'(T) + 1);
        stuck = 1'b0;
        @(negedge clock);

        // reset in the middle of WAIT
        wait_idle();
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_wait_state", 32'(cstate), 32'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        flush_model();

        // eps_load coinciding with DECAY
        do_load(16'd20, 16'd4);
        eng_mode = 1; fix_d = 3; fix_nh_en = 1'b0;
        dload_en = 1'b1; dload_val = 16'd50;
        wait_idle();
        snap = n_done;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (cstate == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_decay", 32'(ok), 32'd1);
        eps_load = 1'b1;
        eps_init = 16'd50;
        @(negedge clock);
        eps_load = 1'b0;
        check("eps_load_in_decay", 32'(epsilon), 32'd50);
        wait_done(snap + 1);
        dload_en = 1'b0;

        // randomized decisions with random backpressure
        eng_mode = 0;
        rand_bp  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 6 == 0) do_load(16'($urandom_range(0, 60)), 16'($urandom_range(0, 9)));
            run_one(-1);
        end
        rand_bp = 1'b0;
        repeat (5) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
